div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_pkg.sv | 6 +
 rtl/div_core.sv | 51 +++++
 rtl/div_sched.sv | 76 +++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared states and sizing for the div_sched block
package div_pkg;
  localparam int NREQ = 2;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/div_core.sv
// div_core: iterative restoring divider, one quotient bit per cycle MSB first
module div_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] rem, d;
  logic [WIDTH:0] sh;
  logic [CW-1:0] cnt;
  logic busy, ge;
  // sh is the WIDTH+1 bit partial remainder; the stored remainder stays below d
  assign sh = {rem, q[WIDTH-1]};
  assign ge = sh >= {1'b0, d};
  assign r = rem;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      q    <= '0;
      d    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q    <= a;
        d    <= b;
        rem  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem <= ge ? WIDTH'(sh - {1'b0, d}) : sh[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], ge};
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin arbiter for two requesters sharing one divider
module div_sched import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_q,
  output logic [WIDTH-1:0]      rsp_r,
  output logic                  rsp_dz
);
  state_t state, state_n;
  logic last, id, gid, xfer, bz, core_done;
  logic [WIDTH-1:0] a_sel, b_sel, core_q, core_r;
  assign gid = &req_valid ? ~last : req_valid[1];
  assign req_ready = (state == IDLE && !rst && |req_valid) ? {gid, ~gid} : '0;
  assign xfer = |(req_valid & req_ready);
  assign a_sel = gid ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign b_sel = gid ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign bz = b_sel == '0;
  assign rsp_valid = state == DONE;
  div_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .start(xfer && !bz),
    .a    (a_sel),
    .b    (b_sel),
    .done (core_done),
    .q    (core_q),
    .r    (core_r)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = xfer ? (bz ? DONE : BUSY) : IDLE;
      BUSY:    state_n = core_done ? DONE : BUSY;
      DONE:    state_n = rsp_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      id     <= 1'b0;
      rsp_id <= 1'b0;
      rsp_q  <= '0;
      rsp_r  <= '0;
      rsp_dz <= 1'b0;
    end else begin
      state <= state_n;
      if (xfer) begin
        last <= gid;
        id   <= gid;
      end
      // divide by zero skips the core and answers on the accepting edge
      if (xfer && bz) begin
        rsp_id <= gid;
        rsp_q  <= '1;
        rsp_r  <= a_sel;
        rsp_dz <= 1'b1;
      end else if (state == BUSY && core_done) begin
        rsp_id <= id;
        rsp_q  <= core_q;
        rsp_r  <= core_r;
        rsp_dz <= 1'b0;
      end
    end
  end
endmodule
